// File: rtl/flt.sv
`default_nettype none
// ============================================================================
//  Module   : flt
//  Purpose  : Registered IEEE-754 binary32 "less-than" comparator for the
//             floating-point ALU. When enabled it produces a 32-bit boolean
//             result (0x1 when A < B, otherwise 0x0) one clock later.
//  Ports    : clk        - clock, rising-edge active
//             rst_n      - asynchronous active-low reset
//             Flt_en     - operation enable, sampled on rising clk
//             read_data1 - operand A, binary32
//             read_data2 - operand B, binary32
//             ltdata_out - registered result, bit 0 = (A < B), bits 31:1 = 0
//  Revision : 1.0 - initial release
// ============================================================================
module flt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Flt_en,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    output logic [31:0] ltdata_out
);

    logic w_a_nan;
    logic w_b_nan;
    logic w_a_zero;
    logic w_b_zero;
    logic w_mag_lt;
    logic w_mag_gt;
    logic w_lt;
    logic r_lt;

    // Field decode. Denormals need no special case: for same-sign finite
    // values the {exponent, fraction} bit pattern is already monotonic in
    // magnitude, and infinities sit above every finite magnitude.
    assign w_a_nan  = (read_data1[30:23] == 8'hFF) && (read_data1[22:0] != 23'd0);
    assign w_b_nan  = (read_data2[30:23] == 8'hFF) && (read_data2[22:0] != 23'd0);
    assign w_a_zero = (read_data1[30:0] == 31'd0);
    assign w_b_zero = (read_data2[30:0] == 31'd0);

    assign w_mag_lt = (read_data1[30:0] < read_data2[30:0]);
    assign w_mag_gt = (read_data1[30:0] > read_data2[30:0]);

    // Priority-ordered decision: NaN first (quiet, unordered), then the
    // signed-zero equality, then sign, then magnitude.
    always_comb begin
        w_lt = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_lt = 1'b0;
        end else if (w_a_zero && w_b_zero) begin
            w_lt = 1'b0;
        end else if (read_data1[31] != read_data2[31]) begin
            w_lt = read_data1[31];
        end else if (!read_data1[31]) begin
            w_lt = w_mag_lt;
        end else begin
            // Both negative: larger magnitude is the smaller value.
            w_lt = w_mag_gt;
        end
    end

    // Only the boolean bit is stored; disabled cycles clear it so the
    // write-back value reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lt <= 1'b0;
        end else begin
            r_lt <= Flt_en & w_lt;
        end
    end

    assign ltdata_out = {31'd0, r_lt};

endmodule
`default_nettype wire

// File: tb/tb_flt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flt
//  Purpose  : Scoreboard testbench for flt. Stimulus pushes expected results
//             computed by an ordering-key reference model; a monitor pops and
//             compares one entry after every rising clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flt;

    logic        clk;
    logic        rst_n;
    logic        Flt_en;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] ltdata_out;

    int checks;
    int errors;

    logic [31:0] exp_q[$];
    string       name_q[$];

    flt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Flt_en     (Flt_en),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .ltdata_out (ltdata_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: map every non-NaN float onto a signed integer key whose
    // natural order is the real-number order (+0 and -0 both map to 0).
    function automatic longint key_of(input logic [31:0] v);
        longint mag;
        mag = longint'({1'b0, v[30:0]});
        return v[31] ? -mag : mag;
    endfunction

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic en);
        if (!en) return 32'h0;
        if (is_nan(a) || is_nan(b)) return 32'h0;
        return (key_of(a) < key_of(b)) ? 32'h1 : 32'h0;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic en,
                         input string nm);
        @(negedge clk);
        read_data1 = a;
        read_data2 = b;
        Flt_en     = en;
        exp_q.push_back(model(a, b, en));
        name_q.push_back(nm);
    endtask

    task automatic check_now(input logic [31:0] exp, input string nm);
        checks++;
        if (ltdata_out !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, ltdata_out, exp);
        end
    endtask

    // Monitor: one result is due after each edge following a pushed stimulus.
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (ltdata_out !== e) begin
                    errors++;
                    $display("FAIL %s: got %08h expected %08h a=%08h b=%08h",
                             n, ltdata_out, e, read_data1, read_data2);
                end
            end
        end
    end

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h7F800000 | ($urandom_range(0, 1) ? 32'h00400000 : 32'h0); // inf / NaN
            1: v = 32'h0;                                                           // zero
            2: v = {9'd0, 23'($urandom())};                                         // denormal
            3: v = 32'h7F7FFFFF;                                                    // max finite
            default: v = $urandom();
        endcase
        if ($urandom_range(0, 1) != 0) v[31] = ~v[31];
        return v;
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          budget;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        Flt_en     = 1'b0;
        read_data1 = 32'h0;
        read_data2 = 32'h0;

        #12;
        check_now(32'h0, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while the output holds 1.
        drive(32'hC1433333, 32'h41600000, 1'b1, "pre_reset_one");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_now(32'h0, "async_reset_drop");
        @(posedge clk);
        #1;
        check_now(32'h0, "reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        drive(32'h40200000, 32'h40200000, 1'b1, "eq_2p5");
        drive(32'hC1433333, 32'h41600000, 1'b1, "neg_vs_pos");
        drive(32'h43160000, 32'hC3340000, 1'b1, "pos_vs_neg");
        drive(32'hC0966666, 32'hC093851F, 1'b1, "both_neg");
        drive(32'h42000000, 32'h42000106, 1'b1, "both_pos");
        drive(32'h42680000, 32'h42680000, 1'b1, "eq_58");
        drive(32'h42E00000, 32'h42F00000, 1'b0, "disabled");
        drive(32'h42E00000, 32'h42F00000, 1'b1, "enabled");
        drive(32'h00000000, 32'h80000000, 1'b1, "pz_vs_nz");
        drive(32'h80000000, 32'h00000000, 1'b1, "nz_vs_pz");
        drive(32'h7FC00000, 32'h3F800000, 1'b1, "nan_a");
        drive(32'h3F800000, 32'h7FC00000, 1'b1, "nan_b");
        drive(32'hFF800000, 32'hFF7FFFFF, 1'b1, "ninf_vs_nmax");
        drive(32'h00000001, 32'h00000002, 1'b1, "denorm");
        drive(32'hFF800000, 32'h7F800000, 1'b1, "ninf_vs_pinf");
        drive(32'h80000001, 32'h00000000, 1'b1, "nden_vs_pz");

        // Back-to-back toggling.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(32'h3F800000, 32'h40000000, 1'b1, "toggle_true");
            else            drive(32'h40000000, 32'h3F800000, 1'b1, "toggle_false");
        end

        // Randomized pairs, including near-equal and equal operands.
        for (int i = 0; i < 400; i++) begin
            a = rand_operand();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a + 32'($urandom_range(0, 2)) - 32'd1;
                default: b = rand_operand();
            endcase
            drive(a, b, ($urandom_range(0, 7) != 0), "random");
        end

        @(negedge clk);
        Flt_en = 1'b0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
